// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens and alignment state type
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } tmds_align_state_t;

endpackage

// File: rtl/tmds_decoder_if.sv
// rtl/tmds_decoder_if.sv - character input and decoded output bundle of one TMDS channel
interface tmds_decoder_if;
    import tmds_pkg::*;

    logic [9:0] tmds_in;
    logic [7:0] data_out;
    logic       ve_out;
    logic [1:0] control_out;
    logic       locked_out;
    logic       bitslip_out;

    // deserializer / capture side
    modport master (
        output tmds_in,
        input  data_out, ve_out, control_out, locked_out, bitslip_out
    );

    // decoder side
    modport slave (
        input  tmds_in,
        output data_out, ve_out, control_out, locked_out, bitslip_out
    );
endinterface

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - combinational decode of one 10-bit TMDS character
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] tmds_i,
    output logic       is_token_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);

    logic [7:0] q;

    // token match and inverse of the transition-minimising stage
    always_comb begin
        is_token_o = 1'b1;
        ctrl_o     = 2'b00;
        unique case (tmds_i)
            CTRL_TOKEN_00: ctrl_o = 2'b00;
            CTRL_TOKEN_01: ctrl_o = 2'b01;
            CTRL_TOKEN_10: ctrl_o = 2'b10;
            CTRL_TOKEN_11: ctrl_o = 2'b11;
            default:       is_token_o = 1'b0;
        endcase

        q         = tmds_i[9] ? ~tmds_i[7:0] : tmds_i[7:0];
        data_o    = 8'h00;
        data_o[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            data_o[i] = tmds_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with word-alignment state machine
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 4,
    parameter int LOSS_TIMEOUT   = 8192
) (
    input  logic          clk_in,
    input  logic          rst_in,
    tmds_decoder_if.slave bus
);

    localparam int TOK_W = $clog2(LOCK_COUNT + 1);
    localparam int TIM_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SET_W = $clog2(SLIP_SETTLE + 1);
    localparam int GAP_W = $clog2(LOSS_TIMEOUT + 1);

    logic       is_tok;
    logic [1:0] dec_ctrl;
    logic [7:0] dec_data;

    tmds_word_decode u_word_decode (
        .tmds_i     (bus.tmds_in),
        .is_token_o (is_tok),
        .ctrl_o     (dec_ctrl),
        .data_o     (dec_data)
    );

    logic [7:0]        data_q, data_d;
    logic              ve_q, ve_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              locked_q, locked_d;
    logic              slip_q, slip_d;
    tmds_align_state_t state_q, state_d;
    logic [TOK_W-1:0]  tok_q, tok_d, tok_inc;
    logic [TIM_W-1:0]  timer_q, timer_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [GAP_W-1:0]  gap_q, gap_d, gap_inc;

    // decoded outputs follow the input every cycle; control value is sticky across data
    always_comb begin
        data_d = is_tok ? 8'h00 : dec_data;
        ve_d   = ~is_tok;
        ctrl_d = is_tok ? dec_ctrl : ctrl_q;
    end

    // alignment FSM next state; lock takes priority over a slip on the same cycle
    always_comb begin
        state_d  = state_q;
        tok_d    = tok_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        gap_d    = gap_q;
        locked_d = locked_q;
        slip_d   = 1'b0;

        tok_inc = !is_tok ? '0 :
                  (tok_q == TOK_W'(LOCK_COUNT)) ? tok_q : tok_q + TOK_W'(1);
        gap_inc = is_tok ? '0 :
                  (gap_q == GAP_W'(LOSS_TIMEOUT)) ? gap_q : gap_q + GAP_W'(1);

        unique case (state_q)
            SEARCH: begin
                tok_d   = tok_inc;
                timer_d = (timer_q == TIM_W'(SEARCH_TIMEOUT)) ? timer_q : timer_q + TIM_W'(1);
                if (tok_inc == TOK_W'(LOCK_COUNT)) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    tok_d    = '0;
                    timer_d  = '0;
                    gap_d    = '0;
                end else if (timer_q == TIM_W'(SEARCH_TIMEOUT - 1)) begin
                    state_d  = SLIP_WAIT;
                    slip_d   = 1'b1;
                    tok_d    = '0;
                    timer_d  = '0;
                    settle_d = '0;
                end
            end
            SLIP_WAIT: begin
                if (settle_q == SET_W'(SLIP_SETTLE - 1)) begin
                    state_d  = SEARCH;
                    tok_d    = '0;
                    timer_d  = '0;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            LOCKED: begin
                gap_d = gap_inc;
                if (gap_inc == GAP_W'(LOSS_TIMEOUT)) begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                    tok_d    = '0;
                    timer_d  = '0;
                    gap_d    = '0;
                end
            end
            default: begin
                state_d  = SEARCH;
                locked_d = 1'b0;
                tok_d    = '0;
                timer_d  = '0;
                settle_d = '0;
                gap_d    = '0;
            end
        endcase
    end

    // all state and outputs registered; reset cancels any pending settle period
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_q   <= '0;
            ve_q     <= 1'b0;
            ctrl_q   <= '0;
            locked_q <= 1'b0;
            slip_q   <= 1'b0;
            state_q  <= SEARCH;
            tok_q    <= '0;
            timer_q  <= '0;
            settle_q <= '0;
            gap_q    <= '0;
        end else begin
            data_q   <= data_d;
            ve_q     <= ve_d;
            ctrl_q   <= ctrl_d;
            locked_q <= locked_d;
            slip_q   <= slip_d;
            state_q  <= state_d;
            tok_q    <= tok_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            gap_q    <= gap_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.ve_out      = ve_q;
    assign bus.control_out = ctrl_q;
    assign bus.locked_out  = locked_q;
    assign bus.bitslip_out = slip_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed self-checking bench for tmds_decoder
module tb_tmds_decoder;
    import tmds_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   enc_cnt = 0;

    always #5 clk_in = ~clk_in;

    tmds_decoder_if bus ();

    tmds_decoder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        logic [9:0] tmds;
        logic [7:0] exp_data;
        logic       exp_ve;
        logic [1:0] exp_ctrl;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // apply one character and wait past the capturing edge
    task automatic step(input logic [9:0] v);
        bus.tmds_in = v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step(10'h100);
        rst_in = 1'b0;
    endtask

    // reference DVI encoder with running disparity
    task automatic encode(input logic [7:0] d, output logic [9:0] o);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + (n0q - n1q);
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + (n1q - n0q);
        end
    endtask

    initial begin
        logic [9:0] w;
        int pulses [$];
        int saw_lock;
        int saw_slip;
        logic prev_slip;

        vecs[0] = '{10'h100, 8'h00, 1'b1, 2'b00};
        vecs[1] = '{10'h2FF, 8'hFE, 1'b1, 2'b00};
        vecs[2] = '{10'h0AB, 8'h00, 1'b0, 2'b01};
        vecs[3] = '{10'h100, 8'h00, 1'b1, 2'b01};
        vecs[4] = '{10'h154, 8'h00, 1'b0, 2'b10};
        vecs[5] = '{10'h2FF, 8'hFE, 1'b1, 2'b10};
        vecs[6] = '{10'h2AB, 8'h00, 1'b0, 2'b11};
        vecs[7] = '{10'h354, 8'h00, 1'b0, 2'b00};
        vecs[8] = '{10'h1FF, 8'h01, 1'b1, 2'b00};
        vecs[9] = '{10'h3AA, 8'hFF, 1'b1, 2'b00};

        bus.tmds_in = 10'h2FF;
        do_reset();
        chk("reset data", {24'd0, bus.data_out}, 32'd0);
        chk("reset ve", {31'd0, bus.ve_out}, 32'd0);
        chk("reset ctrl", {30'd0, bus.control_out}, 32'd0);
        chk("reset locked", {31'd0, bus.locked_out}, 32'd0);
        chk("reset slip", {31'd0, bus.bitslip_out}, 32'd0);

        // single-character decode table
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].tmds);
            chk($sformatf("vec%0d data", i), {24'd0, bus.data_out}, {24'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d ve", i), {31'd0, bus.ve_out}, {31'd0, vecs[i].exp_ve});
            chk($sformatf("vec%0d ctrl", i), {30'd0, bus.control_out}, {30'd0, vecs[i].exp_ctrl});
        end

        // all byte values through the reference encoder
        enc_cnt = 0;
        for (int b = 0; b < 256; b++) begin
            encode(8'(b), w);
            step(w);
            chk($sformatf("enc byte %0d", b), {23'd0, bus.ve_out, bus.data_out}, {23'd0, 1'b1, 8'(b)});
        end

        // lock after exactly 16 tokens
        do_reset();
        for (int i = 0; i < 15; i++) step(CTRL_TOKEN_00);
        chk("lock after 15", {31'd0, bus.locked_out}, 32'd0);
        step(CTRL_TOKEN_00);
        chk("lock after 16", {31'd0, bus.locked_out}, 32'd1);

        // broken token run does not lock
        do_reset();
        saw_lock = 0;
        for (int i = 0; i < 31; i++) begin
            step((i == 15) ? 10'h100 : CTRL_TOKEN_00);
            if (bus.locked_out) saw_lock++;
        end
        chk("no lock 15+1+15", 32'(saw_lock), 32'd0);

        // bitslip timing on data-only input
        do_reset();
        prev_slip = 1'b0;
        saw_slip = 0;
        for (int i = 0; i < 8300; i++) begin
            step(10'h100);
            if (bus.bitslip_out) pulses.push_back(i);
            if (bus.bitslip_out && prev_slip) saw_slip++;
            prev_slip = bus.bitslip_out;
        end
        chk("slip count", 32'(pulses.size()), 32'd2);
        chk("slip first", (pulses.size() > 0) ? 32'(pulses[0]) : 32'hFFFF_FFFF, 32'd4095);
        chk("slip second", (pulses.size() > 1) ? 32'(pulses[1]) : 32'hFFFF_FFFF, 32'd8195);
        chk("slip back to back", 32'(saw_slip), 32'd0);

        // reset during SLIP_WAIT restarts the search timer from zero
        do_reset();
        for (int i = 0; i < 4097; i++) step(10'h100);
        step(CTRL_TOKEN_11);
        rst_in = 1'b1;
        step(CTRL_TOKEN_11);
        rst_in = 1'b0;
        chk("rst slipwait outs", {18'd0, bus.data_out, bus.ve_out, bus.control_out, bus.locked_out, bus.bitslip_out}, 32'd0);
        pulses.delete();
        for (int i = 0; i < 4100; i++) begin
            step(10'h100);
            if (bus.bitslip_out) pulses.push_back(i);
        end
        chk("slip after rst", (pulses.size() == 1) ? 32'(pulses[0]) : 32'hFFFF_FFFF, 32'd4095);

        // lock loss after 8192 data cycles, without a slip
        do_reset();
        for (int i = 0; i < 16; i++) step(CTRL_TOKEN_00);
        saw_slip = 0;
        for (int i = 0; i < 8191; i++) begin
            step(10'h100);
            if (bus.bitslip_out) saw_slip++;
        end
        chk("locked at 8191", {31'd0, bus.locked_out}, 32'd1);
        step(10'h100);
        chk("unlocked at 8192", {31'd0, bus.locked_out}, 32'd0);
        chk("no slip on loss", {31'd0, bus.bitslip_out} + 32'(saw_slip), 32'd0);

        // reset while locked
        do_reset();
        for (int i = 0; i < 16; i++) step(CTRL_TOKEN_11);
        chk("locked before rst", {30'd0, bus.locked_out, bus.control_out[0]}, 32'd3);
        rst_in = 1'b1;
        step(CTRL_TOKEN_11);
        rst_in = 1'b0;
        chk("rst locked outs", {18'd0, bus.data_out, bus.ve_out, bus.control_out, bus.locked_out, bus.bitslip_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
